// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  SAMPLE_MID = 4'd7;

  // Index of the final data bit for a given data-bits setting (value+5 bits).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
    return {1'b0, data_bits} + 3'd4;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte handshake between the UART receiver and its consumer.
interface uart_rx_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_par_err;
  logic       rx_frm_err;
  logic       rx_ovr_err;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_par_err,
    output rx_frm_err,
    output rx_ovr_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_par_err,
    input  rx_frm_err,
    input  rx_ovr_err,
    output rx_ready
  );

endinterface

// File: rtl/uart_tick_gen.sv
// Oversampling tick prescaler: one-cycle tick every div_i+1 cycles while enabled.
module uart_tick_gen #(
  parameter int DIV_W = 12
) (
  input  logic             app_clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || (cnt_q == '0)) begin
      cnt_d = div_i;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: rxd synchronizer, 16x-oversampled frame FSM and output
// holding register with parity/frame/overrun reporting.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int DIV_W       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             app_clk,
  input  logic             reset_n,
  input  logic             cfg_rx_en,
  input  logic [1:0]       cfg_data_bits,
  input  logic             cfg_stop_bit,
  input  logic             cfg_parity_en,
  input  logic             cfg_even_parity,
  input  logic [DIV_W-1:0] cfg_baud_div,
  input  logic             rxd,
  uart_rx_if.master        rx_if
);

  localparam int SAMP_W = $clog2(OVERSAMPLE);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_prev_q;
  logic                   rxd_s;
  logic                   start_edge;
  logic                   tick;
  logic                   mid;
  logic                   frm_now;

  rx_state_e              state_q;
  logic [SAMP_W-1:0]      samp_cnt_q;
  logic [2:0]             bit_idx_q;
  logic [7:0]             shift_q;
  logic                   par_acc_q;
  logic                   par_err_q;
  logic                   frm_err_q;

  logic [7:0]             data_q;
  logic                   valid_q;
  logic                   out_par_q;
  logic                   out_frm_q;
  logic                   ovr_q;

  uart_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .app_clk (app_clk),
    .reset_n (reset_n),
    .en_i    (cfg_rx_en),
    .div_i   (cfg_baud_div),
    .tick_o  (tick)
  );

  // Synchronizer idles high so a reset never looks like a start edge.
  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '1;
      rxd_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxd_prev_q <= rxd_s;
    end
  end

  assign rxd_s      = sync_q[SYNC_STAGES-1];
  assign start_edge = rxd_prev_q && !rxd_s;
  assign mid        = tick && (samp_cnt_q == SAMPLE_MID);
  assign frm_now    = frm_err_q | ~rxd_s;

  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      samp_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      out_par_q  <= 1'b0;
      out_frm_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end

      if (!cfg_rx_en) begin
        state_q <= IDLE;
      end else if (state_q == IDLE) begin
        if (start_edge) begin
          state_q    <= START;
          samp_cnt_q <= '0;
          bit_idx_q  <= '0;
          shift_q    <= '0;
          par_acc_q  <= 1'b0;
          par_err_q  <= 1'b0;
          frm_err_q  <= 1'b0;
        end
      end else if (tick) begin
        samp_cnt_q <= samp_cnt_q + 1'b1;
        if (mid) begin
          case (state_q)
            START: begin
              state_q <= rxd_s ? IDLE : DATA;
            end
            DATA: begin
              shift_q[bit_idx_q] <= rxd_s;
              par_acc_q          <= par_acc_q ^ rxd_s;
              if (bit_idx_q == last_bit_idx(cfg_data_bits)) begin
                state_q <= cfg_parity_en ? PARITY : STOP1;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end
            PARITY: begin
              par_err_q <= par_acc_q ^ rxd_s ^ ~cfg_even_parity;
              state_q   <= STOP1;
            end
            STOP1, STOP2: begin
              frm_err_q <= frm_now;
              if (state_q == STOP1 && cfg_stop_bit) begin
                state_q <= STOP2;
              end else begin
                // Commit: a held, unaccepted byte wins over the new one.
                state_q <= IDLE;
                if (valid_q && !rx_if.rx_ready) begin
                  ovr_q <= 1'b1;
                end else begin
                  data_q    <= shift_q;
                  out_par_q <= par_err_q;
                  out_frm_q <= frm_now;
                  valid_q   <= 1'b1;
                end
              end
            end
            default: begin
              state_q <= IDLE;
            end
          endcase
        end
      end
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.rx_par_err = out_par_q;
  assign rx_if.rx_frm_err = out_frm_q;
  assign rx_if.rx_ovr_err = ovr_q;

endmodule
